// File: rtl/recirc_pkg.sv
// recirc_pkg: shared state encodings and defaults for the
// recirculation link-bring-up controller.
package recirc_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_RESET  = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_LOCK   = 2'd2;
  localparam state_t ST_ACTIVE = 2'd3;

  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/lane_router.sv
// lane_router: registered two-way steer for one lane.
// sel=1 drives the pass-through side, sel=0 the recirculation side.
module lane_router
  import recirc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sel,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_r,
  output logic              valid_r
);

  // Unselected data bus keeps its last word; only its valid drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out  <= '0;
      valid_out <= 1'b0;
      data_r    <= '0;
      valid_r   <= 1'b0;
    end else if (sel) begin
      data_out  <= data;
      valid_out <= valid;
      valid_r   <= 1'b0;
    end else begin
      data_r    <= data;
      valid_r   <= valid;
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/recirc_ctrl.sv
// recirc_ctrl: idle_out debounce FSM and four-lane steering.
// Optional RECIRC_STATS_EN adds a saturating recirc_count.
module recirc_ctrl
  import recirc_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int IDLE_CNT = 4
`ifdef RECIRC_STATS_EN
  ,
  parameter int CNT_W    = 8
`endif
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              idle_out,
  input  logic [DATA_W-1:0] data_0,
  input  logic [DATA_W-1:0] data_1,
  input  logic [DATA_W-1:0] data_2,
  input  logic [DATA_W-1:0] data_3,
  input  logic              valid_0,
  input  logic              valid_1,
  input  logic              valid_2,
  input  logic              valid_3,
  output logic [DATA_W-1:0] data_0_out,
  output logic [DATA_W-1:0] data_1_out,
  output logic [DATA_W-1:0] data_2_out,
  output logic [DATA_W-1:0] data_3_out,
  output logic              valid_0_out,
  output logic              valid_1_out,
  output logic              valid_2_out,
  output logic              valid_3_out,
  output logic [DATA_W-1:0] data_0r,
  output logic [DATA_W-1:0] data_1r,
  output logic [DATA_W-1:0] data_2r,
  output logic [DATA_W-1:0] data_3r,
  output logic              valid_0r,
  output logic              valid_1r,
  output logic              valid_2r,
  output logic              valid_3r,
  output logic              active,
  output logic [1:0]        state
`ifdef RECIRC_STATS_EN
  ,
  output logic [CNT_W-1:0]  recirc_count
`endif
);

  localparam logic [7:0] LOCK_LAST = 8'(IDLE_CNT - 1);

  state_t     st_q;
  state_t     st_d;
  logic [7:0] lock_q;
  logic [7:0] lock_d;
  logic       sel;

  logic [DATA_W-1:0] din [4];
  logic [DATA_W-1:0] qo  [4];
  logic [DATA_W-1:0] qr  [4];
  logic [3:0]        vin;
  logic [3:0]        vo;
  logic [3:0]        vr;

  always_comb begin
    st_d   = st_q;
    lock_d = lock_q;
    unique case (st_q)
      ST_RESET: begin
        st_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (idle_out) begin
          if (IDLE_CNT == 1) begin
            st_d = ST_ACTIVE;
          end else begin
            st_d   = ST_LOCK;
            lock_d = 8'd1;
          end
        end
      end
      ST_LOCK: begin
        if (!idle_out) begin
          st_d   = ST_WAIT;
          lock_d = '0;
        end else if (lock_q == LOCK_LAST) begin
          st_d = ST_ACTIVE;
        end else begin
          lock_d = lock_q + 8'd1;
        end
      end
      ST_ACTIVE: begin
        if (!idle_out) begin
          st_d   = ST_WAIT;
          lock_d = '0;
        end
      end
      default: begin
        st_d   = ST_RESET;
        lock_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      st_q   <= ST_RESET;
      lock_q <= '0;
      active <= 1'b0;
    end else begin
      st_q   <= st_d;
      lock_q <= lock_d;
      active <= (st_d == ST_ACTIVE);
    end
  end

  assign state = st_q;

  // Route follows the pre-transition state so each word lands once.
  assign sel = (st_q == ST_ACTIVE);

  assign din[0] = data_0;
  assign din[1] = data_1;
  assign din[2] = data_2;
  assign din[3] = data_3;
  assign vin    = {valid_3, valid_2, valid_1, valid_0};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    lane_router #(
      .DATA_W(DATA_W)
    ) u_lane (
      .clk      (clk_f),
      .reset    (reset),
      .sel      (sel),
      .data     (din[i]),
      .valid    (vin[i]),
      .data_out (qo[i]),
      .valid_out(vo[i]),
      .data_r   (qr[i]),
      .valid_r  (vr[i])
    );
  end

  assign data_0_out  = qo[0];
  assign data_1_out  = qo[1];
  assign data_2_out  = qo[2];
  assign data_3_out  = qo[3];
  assign valid_0_out = vo[0];
  assign valid_1_out = vo[1];
  assign valid_2_out = vo[2];
  assign valid_3_out = vo[3];
  assign data_0r     = qr[0];
  assign data_1r     = qr[1];
  assign data_2r     = qr[2];
  assign data_3r     = qr[3];
  assign valid_0r    = vr[0];
  assign valid_1r    = vr[1];
  assign valid_2r    = vr[2];
  assign valid_3r    = vr[3];

`ifdef RECIRC_STATS_EN
  logic [2:0]     n_r;
  logic [CNT_W:0] sum;

  always_comb begin
    n_r = '0;
    if (!sel) begin
      for (int i = 0; i < 4; i++) begin
        n_r = n_r + {2'b00, vin[i]};
      end
    end
  end

  assign sum = {1'b0, recirc_count} + (CNT_W+1)'(n_r);

  always_ff @(posedge clk_f) begin
    if (reset) begin
      recirc_count <= '0;
    end else if (sum[CNT_W]) begin
      recirc_count <= '1;
    end else begin
      recirc_count <= sum[CNT_W-1:0];
    end
  end
`endif

endmodule
